// File: rtl/layer_stats_if.sv
// Row-input / statistics-output handshake bundle for layer_stats.
// A transfer happens on a rising edge where valid and ready are both high; valid holds its data until then.
interface layer_stats_if #(
    parameter int SIZE = 16,
    parameter int IL   = 4,
    parameter int FL   = 16
);
    localparam int W = IL + FL;

    logic                   in_valid;
    logic                   in_ready;
    logic [SIZE-1:0][W-1:0] inp;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [W-1:0]    mean;
    logic signed [W-1:0]    variance;

    modport master (
        output in_valid, inp, out_ready,
        input  in_ready, out_valid, mean, variance
    );

    modport slave (
        input  in_valid, inp, out_ready,
        output in_ready, out_valid, mean, variance
    );
endinterface

// File: rtl/layer_stats.sv
// Streaming tile mean/variance: accumulates ROWS beats of SIZE signed fixed-point
// values, then computes floor-rounded mean and saturated variance in one CALC cycle.
module layer_stats #(
    parameter int SIZE = 16,
    parameter int ROWS = 16,
    parameter int IL   = 4,
    parameter int FL   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    layer_stats_if.slave bus,
    output logic [1:0]   dbg_state
);
    localparam int W    = IL + FL;
    localparam int LN   = $clog2(SIZE * ROWS);
    localparam int SUMW = W + LN;
    localparam int SQW  = 2 * W + LN;
    localparam int CW   = $clog2(ROWS) + 1;
    localparam logic [CW-1:0] LAST = CW'(ROWS - 1);
    localparam logic signed [SQW:0] VMAX = {{(SQW + 2 - W){1'b0}}, {(W - 1){1'b1}}};

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic signed [SUMW-1:0] r_sum;
    logic signed [SQW-1:0]  r_sumsq;
    logic signed [W-1:0]    r_mean;
    logic signed [W-1:0]    r_var;
    logic                   r_out_valid;

    logic signed [W-1:0]    w_e [SIZE];
    logic signed [2*W-1:0]  w_p [SIZE];
    logic signed [SUMW-1:0] w_row_sum;
    logic signed [SQW-1:0]  w_row_sq;
    logic signed [W-1:0]    w_mean;
    logic signed [2*W-1:0]  w_mean_sq;
    logic signed [SQW-1:0]  w_sq_avg;
    logic signed [SQW:0]    w_diff;
    logic signed [SQW:0]    w_var_sh;
    logic signed [W-1:0]    w_var_sat;

    for (genvar k = 0; k < SIZE; k++) begin : g_elem
        assign w_e[k] = bus.inp[k];
        assign w_p[k] = w_e[k] * w_e[k];
    end

    always_comb begin
        w_row_sum = '0;
        w_row_sq  = '0;
        for (int k = 0; k < SIZE; k++) begin
            w_row_sum = w_row_sum + SUMW'(w_e[k]);
            w_row_sq  = w_row_sq + SQW'(w_p[k]);
        end
    end

    // mean of the full tile always fits W bits, so truncation after the shift is exact
    assign w_mean    = W'(r_sum >>> LN);
    assign w_mean_sq = w_mean * w_mean;
    assign w_sq_avg  = r_sumsq >>> LN;
    assign w_diff    = (SQW + 1)'(w_sq_avg) - (SQW + 1)'(w_mean_sq);
    assign w_var_sh  = w_diff >>> FL;

    always_comb begin
        w_var_sat = W'(w_var_sh);
        if (w_var_sh < 0)
            w_var_sat = '0;
        else if (w_var_sh > VMAX)
            w_var_sat = W'(VMAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ACC;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_sumsq     <= '0;
            r_mean      <= '0;
            r_var       <= '0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_state     <= ACC;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_sumsq     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (bus.in_valid) begin
                        r_sum   <= r_sum + w_row_sum;
                        r_sumsq <= r_sumsq + w_row_sq;
                        if (r_cnt == LAST) begin
                            r_cnt   <= '0;
                            r_state <= CALC;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                CALC: begin
                    r_mean      <= w_mean;
                    r_var       <= w_var_sat;
                    r_out_valid <= 1'b1;
                    r_sum       <= '0;
                    r_sumsq     <= '0;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ACC;
                    end
                end
                default: r_state <= ACC;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ACC);
    assign bus.out_valid = r_out_valid;
    assign bus.mean      = r_mean;
    assign bus.variance  = r_var;
    assign dbg_state     = r_state;
endmodule

// File: tb/tb_layer_stats.sv
// Directed bench for layer_stats with SIZE=4, ROWS=4, IL=4, FL=8 (1.0 = 256).
module tb_layer_stats;
    localparam int SIZE = 4;
    localparam int ROWS = 4;
    localparam int IL   = 4;
    localparam int FL   = 8;
    localparam int W    = IL + FL;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic [1:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;

    layer_stats_if #(.SIZE(SIZE), .IL(IL), .FL(FL)) bus ();

    layer_stats #(.SIZE(SIZE), .ROWS(ROWS), .IL(IL), .FL(FL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int a, input int b);
        for (int k = 0; k < SIZE; k++)
            bus.inp[k] = (k % 2 == 0) ? W'(a) : W'(b);
    endtask

    task automatic send_row(input int a, input int b);
        set_row(a, b);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // four back-to-back beats, then latency and result checks
    task automatic send_tile(input int ra[4], input int rb[4], input int e_mean,
                             input int e_var, input string tag);
        for (int r = 0; r < ROWS; r++) begin
            set_row(ra[r], rb[r]);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        check({tag, "_calc_state"}, int'(dbg_state), 1);
        check({tag, "_calc_ov"}, int'(bus.out_valid), 0);
        check({tag, "_calc_rdy"}, int'(bus.in_ready), 0);
        tick();
        check({tag, "_ov"}, int'(bus.out_valid), 1);
        check({tag, "_mean"}, int'(bus.mean), e_mean);
        check({tag, "_var"}, int'(bus.variance), e_var);
    endtask

    task automatic take_result(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_done_ov"}, int'(bus.out_valid), 0);
        check({tag, "_done_rdy"}, int'(bus.in_ready), 1);
    endtask

    initial begin
        int ra[4];
        int rb[4];
        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_row(0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_rdy", int'(bus.in_ready), 1);
        check("rst_ov", int'(bus.out_valid), 0);
        check("rst_mean", int'(bus.mean), 0);
        check("rst_var", int'(bus.variance), 0);

        ra = '{256, 256, 256, 256};
        rb = ra;
        send_tile(ra, rb, 256, 0, "ones");
        take_result("ones");

        ra = '{512, 512, -512, -512};
        rb = ra;
        send_tile(ra, rb, 0, 1024, "pm512");
        take_result("pm512");

        ra = '{2047, 2047, 2047, 2047};
        rb = '{-2048, -2048, -2048, -2048};
        send_tile(ra, rb, -1, 2047, "extreme");
        take_result("extreme");

        // result held under back-pressure; input pulses must be ignored
        ra = '{-256, -256, -256, -256};
        rb = ra;
        send_tile(ra, rb, -256, 0, "hold");
        for (int c = 0; c < 5; c++) begin
            set_row(1000, -1000);
            bus.in_valid = (c % 2 == 0);
            tick();
            check("hold_ov", int'(bus.out_valid), 1);
            check("hold_mean", int'(bus.mean), -256);
            check("hold_var", int'(bus.variance), 0);
            check("hold_rdy", int'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        take_result("hold");

        // partial tile discarded by clear, even with a beat offered on the same edge
        send_row(100, 100);
        send_row(100, 100);
        set_row(100, 100);
        bus.in_valid = 1'b1;
        clear        = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        clear        = 1'b0;
        check("clr_state", int'(dbg_state), 0);
        check("clr_rdy", int'(bus.in_ready), 1);
        check("clr_mean_kept", int'(bus.mean), -256);
        ra = '{768, 768, 768, 768};
        rb = ra;
        send_tile(ra, rb, 768, 0, "clr");
        take_result("clr");

        // reset while holding a result
        ra = '{256, 256, 256, 256};
        rb = ra;
        send_tile(ra, rb, 256, 0, "prehold");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rsthold_ov", int'(bus.out_valid), 0);
        check("rsthold_mean", int'(bus.mean), 0);
        check("rsthold_var", int'(bus.variance), 0);
        check("rsthold_rdy", int'(bus.in_ready), 1);

        // reset in the middle of accumulation
        send_row(512, 512);
        send_row(-1024, 700);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstacc_rdy", int'(bus.in_ready), 1);
        check("rstacc_state", int'(dbg_state), 0);
        ra = '{256, 256, 256, 256};
        rb = ra;
        send_tile(ra, rb, 256, 0, "fresh");
        take_result("fresh");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
